// File: rtl/hc_pkg.sv
// hc_pkg: shared types and constants for the host-channel loopback sample.
//   loopback_state_t     - sequencing states of loopback_sched
//   LOOPBACK_FIFO_DEPTH  - depth of the loopback_fifo paired with loopback_sched
package hc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } loopback_state_t;

   localparam int LOOPBACK_FIFO_DEPTH = 8;

endpackage

// File: rtl/loopback_sched.sv
// loopback_sched: copies num_lines lines from src_addr to dst_addr via an
// external loopback_fifo. Reads are issued only while outstanding reads plus
// FIFO occupancy leave room, so the FIFO can never overflow. Writes drain the
// FIFO head; done pulses once every write has been acknowledged.
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   start, src_addr, dst_addr, num_lines - transfer launch (sampled in IDLE)
//   rd_req_*           - registered read requests, rd_req_almfull backpressure
//   rd_rsp_valid       - read response strobe (data goes straight to the FIFO)
//   fifo_*             - FIFO enqueue/dequeue and status
//   wr_req_*           - registered write requests, wr_req_almfull backpressure
//   wr_rsp_valid       - write acknowledge, one per line
//   busy, done         - status: busy in RUN/DRAIN, done one cycle at the end
module loopback_sched
   import hc_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int FIFO_DEPTH = LOOPBACK_FIFO_DEPTH,
   parameter int ADDR_WIDTH = 42,
   parameter int LEN_WIDTH  = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [ADDR_WIDTH-1:0]         src_addr,
   input  logic [ADDR_WIDTH-1:0]         dst_addr,
   input  logic [LEN_WIDTH-1:0]          num_lines,
   output logic                          rd_req_valid,
   output logic [ADDR_WIDTH-1:0]         rd_req_addr,
   input  logic                          rd_req_almfull,
   input  logic                          rd_rsp_valid,
   output logic                          fifo_enq_en,
   input  logic                          fifo_full,
   input  logic                          fifo_empty,
   input  logic [$clog2(FIFO_DEPTH):0]   fifo_counter,
   input  logic [DATA_WIDTH-1:0]         fifo_deq_data,
   output logic                          fifo_deq_en,
   output logic                          wr_req_valid,
   output logic [ADDR_WIDTH-1:0]         wr_req_addr,
   output logic [DATA_WIDTH-1:0]         wr_req_data,
   input  logic                          wr_req_almfull,
   input  logic                          wr_rsp_valid,
   output logic                          busy,
   output logic                          done
);

   localparam logic [LEN_WIDTH-1:0] ONE          = LEN_WIDTH'(1);
   // FIFO flags full at DEPTH-1 entries, so that is the credit ceiling.
   localparam logic [LEN_WIDTH:0]   CREDIT_LIMIT = (LEN_WIDTH+1)'(FIFO_DEPTH-1);

   loopback_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0]    src_q, src_d, dst_q, dst_d;
   logic [LEN_WIDTH-1:0]     num_q, num_d;
   logic [LEN_WIDTH-1:0]     rd_sent_q, rd_sent_d, rd_out_q, rd_out_d;
   logic [LEN_WIDTH-1:0]     wr_sent_q, wr_sent_d, wr_acked_q, wr_acked_d;
   logic                     rd_req_valid_q, rd_req_valid_d;
   logic [ADDR_WIDTH-1:0]    rd_req_addr_q, rd_req_addr_d;
   logic                     wr_req_valid_q, wr_req_valid_d;
   logic [ADDR_WIDTH-1:0]    wr_req_addr_q, wr_req_addr_d;
   logic [DATA_WIDTH-1:0]    wr_req_data_q, wr_req_data_d;
   logic                     rd_issue, wr_issue, enq;
   logic [LEN_WIDTH:0]       credit;

   // The credit check keeps the FIFO below full, so the flag itself is unused.
   logic unused_fifo_full;
   assign unused_fifo_full = fifo_full;

   always_comb begin
      state_d        = state_q;
      src_d          = src_q;
      dst_d          = dst_q;
      num_d          = num_q;
      rd_sent_d      = rd_sent_q;
      rd_out_d       = rd_out_q;
      wr_sent_d      = wr_sent_q;
      wr_acked_d     = wr_acked_q;
      rd_req_valid_d = 1'b0;
      rd_req_addr_d  = rd_req_addr_q;
      wr_req_valid_d = 1'b0;
      wr_req_addr_d  = wr_req_addr_q;
      wr_req_data_d  = wr_req_data_q;
      rd_issue       = 1'b0;
      wr_issue       = 1'b0;
      enq            = 1'b0;
      credit         = {1'b0, rd_out_q} + (LEN_WIDTH+1)'(fifo_counter);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               src_d      = src_addr;
               dst_d      = dst_addr;
               num_d      = num_lines;
               rd_sent_d  = '0;
               rd_out_d   = '0;
               wr_sent_d  = '0;
               wr_acked_d = '0;
               state_d    = (num_lines == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            rd_issue = (rd_sent_q < num_q) && !rd_req_almfull && (credit < CREDIT_LIMIT);
            wr_issue = !fifo_empty && !wr_req_almfull && (wr_sent_q < num_q);
            enq      = rd_rsp_valid;
            if (wr_rsp_valid) wr_acked_d = wr_acked_q + ONE;
            if (wr_sent_q == num_q) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (wr_rsp_valid) wr_acked_d = wr_acked_q + ONE;
            // Compare the updated count so done follows the final ack by one cycle.
            if (wr_acked_d == num_q) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (rd_issue) begin
         rd_sent_d      = rd_sent_q + ONE;
         rd_req_valid_d = 1'b1;
         rd_req_addr_d  = src_q + ADDR_WIDTH'(rd_sent_q);
      end

      // Issue and response in the same cycle cancel out.
      if (rd_issue && !enq)      rd_out_d = rd_out_q + ONE;
      else if (!rd_issue && enq) rd_out_d = rd_out_q - ONE;

      if (wr_issue) begin
         wr_sent_d      = wr_sent_q + ONE;
         wr_req_valid_d = 1'b1;
         wr_req_addr_d  = dst_q + ADDR_WIDTH'(wr_sent_q);
         wr_req_data_d  = fifo_deq_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         src_q          <= '0;
         dst_q          <= '0;
         num_q          <= '0;
         rd_sent_q      <= '0;
         rd_out_q       <= '0;
         wr_sent_q      <= '0;
         wr_acked_q     <= '0;
         rd_req_valid_q <= 1'b0;
         rd_req_addr_q  <= '0;
         wr_req_valid_q <= 1'b0;
         wr_req_addr_q  <= '0;
         wr_req_data_q  <= '0;
      end else begin
         state_q        <= state_d;
         src_q          <= src_d;
         dst_q          <= dst_d;
         num_q          <= num_d;
         rd_sent_q      <= rd_sent_d;
         rd_out_q       <= rd_out_d;
         wr_sent_q      <= wr_sent_d;
         wr_acked_q     <= wr_acked_d;
         rd_req_valid_q <= rd_req_valid_d;
         rd_req_addr_q  <= rd_req_addr_d;
         wr_req_valid_q <= wr_req_valid_d;
         wr_req_addr_q  <= wr_req_addr_d;
         wr_req_data_q  <= wr_req_data_d;
      end
   end

   assign rd_req_valid = rd_req_valid_q;
   assign rd_req_addr  = rd_req_addr_q;
   assign wr_req_valid = wr_req_valid_q;
   assign wr_req_addr  = wr_req_addr_q;
   assign wr_req_data  = wr_req_data_q;
   assign fifo_enq_en  = enq;
   assign fifo_deq_en  = wr_issue;
   assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_loopback_sched.sv
// tb_loopback_sched: bench for loopback_sched with a behavioural source memory,
// FIFO and write responder. Expected read/write requests are queued when a
// transfer starts and compared as the DUT emits them.
module tb_loopback_sched;
   import hc_pkg::*;

   localparam int DW    = 512;
   localparam int DEPTH = 8;
   localparam int AW    = 42;
   localparam int LW    = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [AW-1:0]   src_addr, dst_addr;
   logic [LW-1:0]   num_lines;
   logic            rd_req_valid;
   logic [AW-1:0]   rd_req_addr;
   logic            rd_req_almfull;
   logic            rd_rsp_valid;
   logic            fifo_enq_en;
   logic            fifo_full, fifo_empty;
   logic [CW-1:0]   fifo_counter;
   logic [DW-1:0]   fifo_deq_data;
   logic            fifo_deq_en;
   logic            wr_req_valid;
   logic [AW-1:0]   wr_req_addr;
   logic [DW-1:0]   wr_req_data;
   logic            wr_req_almfull;
   logic            wr_rsp_valid;
   logic            busy, done;

   loopback_sched #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .num_lines(num_lines), .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
      .rd_req_almfull(rd_req_almfull), .rd_rsp_valid(rd_rsp_valid), .fifo_enq_en(fifo_enq_en),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_counter(fifo_counter),
      .fifo_deq_data(fifo_deq_data), .fifo_deq_en(fifo_deq_en), .wr_req_valid(wr_req_valid),
      .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_req_almfull(wr_req_almfull),
      .wr_rsp_valid(wr_rsp_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // scoreboard and environment model state
   logic [AW-1:0] exp_rd_q[$];
   logic [AW-1:0] exp_wa_q[$];
   logic [DW-1:0] exp_wd_q[$];
   logic [AW-1:0] pend_rd_q[$];
   logic [DW-1:0] fifo_q[$];
   int ack_pend;
   int n_rd, n_wr, n_done, fifo_bad, first_rd, first_done, last_ack;
   bit busy_seen;
   // knobs applied at the next negedge
   bit knob_rsp, knob_wr_af, knob_rd_rand, start_req;
   logic [AW-1:0] st_src, st_dst;
   logic [LW-1:0] st_num;

   typedef struct {
      int            num;
      logic [AW-1:0] src;
      logic [AW-1:0] dst;
      int            rsp_hold;
      int            wr_af;
      bit            rd_af_rand;
      int            chk_cyc;
      int            exp_rd_chk;
      int            exp_rd;
      int            exp_wr;
      bit            exp_busy;
      bit            chk_lat;
   } vec_t;
   vec_t vecs[7];

   function automatic logic [DW-1:0] datafn(input logic [AW-1:0] a);
      logic [63:0] w;
      w = {22'h2B5A3C, a};
      return {8{w}} ^ {{(DW-AW){1'b0}}, ~a};
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string detail);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, detail);
   endtask

   task automatic clear_models();
      exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
      pend_rd_q.delete(); fifo_q.delete();
      ack_pend = 0;
      knob_rsp = 1'b1; knob_wr_af = 1'b0; knob_rd_rand = 1'b0; start_req = 1'b0;
   endtask

   // One clock: drive at negedge, observe 1 time unit later, then wait for posedge.
   task automatic cycle(input int cyc);
      logic [AW-1:0] a;
      @(negedge clk);
      fifo_counter   = CW'(fifo_q.size());
      fifo_empty     = (fifo_q.size() == 0);
      fifo_full      = (fifo_q.size() >= DEPTH - 1);
      fifo_deq_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      rd_rsp_valid   = knob_rsp && (pend_rd_q.size() > 0);
      wr_rsp_valid   = (ack_pend > 0);
      wr_req_almfull = knob_wr_af;
      rd_req_almfull = knob_rd_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      start          = start_req;
      if (start_req) begin
         src_addr  = st_src;
         dst_addr  = st_dst;
         num_lines = st_num;
      end
      start_req = 1'b0;
      #1;
      if (fifo_deq_en) begin
         if (fifo_q.size() == 0) fifo_bad++;
         else void'(fifo_q.pop_front());
      end
      if (rd_rsp_valid) begin
         a = pend_rd_q.pop_front();
         if (fifo_enq_en) begin
            if (fifo_full) fifo_bad++;
            fifo_q.push_back(datafn(a));
         end
      end
      if (rd_req_valid) begin
         n_rd++;
         if (first_rd < 0) first_rd = cyc;
         if (exp_rd_q.size() == 0) fail_now("rd_extra", $sformatf("unexpected read addr %0h", rd_req_addr));
         else chk("rd_addr", DW'(rd_req_addr), DW'(exp_rd_q.pop_front()));
         pend_rd_q.push_back(rd_req_addr);
      end
      if (wr_req_valid) begin
         n_wr++;
         if (exp_wa_q.size() == 0) fail_now("wr_extra", $sformatf("unexpected write addr %0h", wr_req_addr));
         else begin
            chk("wr_addr", DW'(wr_req_addr), DW'(exp_wa_q.pop_front()));
            chk("wr_data", wr_req_data, exp_wd_q.pop_front());
         end
         ack_pend++;
      end
      if (wr_rsp_valid) begin
         ack_pend--;
         last_ack = cyc;
      end
      if (done) begin
         n_done++;
         if (first_done < 0) first_done = cyc;
      end
      if (busy) busy_seen = 1'b1;
      @(posedge clk);
   endtask

   task automatic run_transfer(input int num, input logic [AW-1:0] s, input logic [AW-1:0] d,
                               input int rsp_hold, input int wr_af, input bit rd_rand,
                               input int chk_cyc, input int abort_wr, output int rd_at_chk);
      int cyc;
      int post;
      n_rd = 0; n_wr = 0; n_done = 0; fifo_bad = 0;
      first_rd = -1; first_done = -1; last_ack = -1; busy_seen = 1'b0;
      rd_at_chk = -1;
      for (int k = 0; k < num; k++) begin
         exp_rd_q.push_back(s + AW'(k));
         exp_wa_q.push_back(d + AW'(k));
         exp_wd_q.push_back(datafn(s + AW'(k)));
      end
      st_src = s; st_dst = d; st_num = LW'(num);
      start_req = 1'b1;
      cyc = 0;
      post = 0;
      while (1) begin
         knob_rsp     = (cyc >= rsp_hold);
         knob_wr_af   = (cyc < wr_af);
         knob_rd_rand = rd_rand;
         if (cyc == chk_cyc) rd_at_chk = n_rd;
         cycle(cyc);
         if (abort_wr > 0 && n_wr >= abort_wr) break;
         if (n_done > 0) post++;
         if (post >= 4) break;
         if (cyc > 3000) begin
            fail_now("timeout", $sformatf("no completion, reads=%0d writes=%0d", n_rd, n_wr));
            break;
         end
         cyc++;
      end
      knob_wr_af = 1'b0; knob_rd_rand = 1'b0; knob_rsp = 1'b1;
   endtask

   initial begin
      int rd_chk;
      reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; num_lines = '0;
      rd_req_almfull = 1'b0; rd_rsp_valid = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
      fifo_counter = '0; fifo_deq_data = '0; wr_req_almfull = 1'b0; wr_rsp_valid = 1'b0;
      clear_models();

      //           num src               dst        hold wr_af rnd chk chkrd rd  wr  busy lat
      vecs[0] = '{0,  42'h10,           42'h20,    0,   0,    0,  -1, 0,    0,  0,  0,   0};
      vecs[1] = '{4,  42'h100,          42'h200,   0,   0,    0,  -1, 0,    4,  4,  1,   1};
      vecs[2] = '{4,  42'h3FF_FFFF_FFFE, 42'h300,  0,   0,    0,  -1, 0,    4,  4,  1,   1};
      vecs[3] = '{16, 42'h1000,         42'h2000,  0,   30,   0,  25, 7,    16, 16, 1,   1};
      vecs[4] = '{20, 42'h5000,         42'h6000,  40,  0,    0,  35, 7,    20, 20, 1,   1};
      vecs[5] = '{9,  42'h7000,         42'h8000,  0,   0,    1,  -1, 0,    9,  9,  1,   0};
      vecs[6] = '{1,  42'hABC,          42'hDEF,   0,   0,    0,  -1, 0,    1,  1,  1,   1};

      @(negedge clk);
      #1;
      chk("reset_outputs", DW'({rd_req_valid, fifo_enq_en, fifo_deq_en, wr_req_valid, busy, done,
                                 |rd_req_addr, |wr_req_addr, |wr_req_data}), '0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);

      foreach (vecs[i]) begin
         run_transfer(vecs[i].num, vecs[i].src, vecs[i].dst, vecs[i].rsp_hold, vecs[i].wr_af,
                      vecs[i].rd_af_rand, vecs[i].chk_cyc, 0, rd_chk);
         chk($sformatf("v%0d_reads", i), DW'(n_rd), DW'(vecs[i].exp_rd));
         chk($sformatf("v%0d_writes", i), DW'(n_wr), DW'(vecs[i].exp_wr));
         chk($sformatf("v%0d_done_pulses", i), DW'(n_done), DW'(1));
         chk($sformatf("v%0d_busy_seen", i), DW'(busy_seen), DW'(vecs[i].exp_busy));
         chk($sformatf("v%0d_fifo_overflow", i), DW'(fifo_bad), '0);
         chk($sformatf("v%0d_leftover", i), DW'(exp_rd_q.size() + exp_wa_q.size() + fifo_q.size()), '0);
         if (vecs[i].chk_cyc >= 0)
            chk($sformatf("v%0d_reads_at_stall", i), DW'(rd_chk), DW'(vecs[i].exp_rd_chk));
         if (vecs[i].num == 0)
            chk($sformatf("v%0d_done_cycle", i), DW'(first_done), DW'(1));
         else
            chk($sformatf("v%0d_done_after_ack", i), DW'(first_done), DW'(last_ack + 1));
         if (vecs[i].chk_lat)
            chk($sformatf("v%0d_first_read_cycle", i), DW'(first_rd), DW'(2));
         clear_models();
      end

      // Reset in the middle of RUN once three writes have gone out.
      run_transfer(8, 42'h9000, 42'hA000, 0, 0, 1'b0, -1, 3, rd_chk);
      chk("mid_writes_before_reset", DW'(n_wr), DW'(3));
      chk("mid_busy_before_reset", DW'(busy), DW'(1));
      #2;
      reset = 1'b1;
      #1;
      chk("mid_reset_outputs", DW'({rd_req_valid, fifo_enq_en, fifo_deq_en, wr_req_valid, busy, done,
                                     |rd_req_addr, |wr_req_addr, |wr_req_data}), '0);
      @(negedge clk);
      reset = 1'b0;
      clear_models();
      // A stale read response arriving in IDLE must not reach the FIFO.
      rd_rsp_valid = 1'b1;
      wr_rsp_valid = 1'b1;
      #1;
      chk("idle_stale_rsp", DW'({fifo_enq_en, busy, done}), '0);
      @(negedge clk);
      rd_rsp_valid = 1'b0;
      wr_rsp_valid = 1'b0;
      #1;
      chk("idle_after_stale", DW'({busy, done, rd_req_valid, wr_req_valid}), '0);
      @(posedge clk);

      run_transfer(2, 42'hB00, 42'hC00, 0, 0, 1'b0, -1, 0, rd_chk);
      chk("post_reset_reads", DW'(n_rd), DW'(2));
      chk("post_reset_writes", DW'(n_wr), DW'(2));
      chk("post_reset_done", DW'(n_done), DW'(1));
      chk("post_reset_overflow", DW'(fifo_bad), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
